// File: rtl/seq_generator.sv
// Free-running generator for T(n+3) = T(n+1) + T(n), seeded 0, 1, 1.
// Emits one term per clock; arithmetic wraps modulo 2^DATA_W.
module seq_generator #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] seq_o
);

  // a, b, c hold T(n), T(n+1), T(n+2)
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] next_c;

  // Carry out is intentionally dropped so the sequence wraps and keeps running
  assign next_c = a + b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= DATA_W'(1);
      c <= DATA_W'(1);
    end else begin
      a <= b;
      b <= c;
      c <= next_c;
    end
  end

  assign seq_o = a;

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: 32-bit and 8-bit (wrapping) instances
// run in lockstep against a table/recurrence reference.
module tb_seq_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seq_32;
  logic [7:0]  seq_8;

  seq_generator #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .seq_o(seq_32));
  seq_generator #(.DATA_W(8))  dut8  (.clk(clk), .reset(reset), .seq_o(seq_8));

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_q32[$];
  logic [7:0]  exp_q8[$];
  string       name_q[$];
  event        sample_ev;

  int unsigned tbl[20] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21, 28, 37, 49, 65, 86, 114};
  logic [31:0] ref32[50];

  // Monitor: pops the expected pair for each sample point and compares both outputs
  always begin
    @(sample_ev);
    if (exp_q32.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL empty_queue: sample with no expected value at %0t", $time);
    end else begin
      logic [31:0] e32;
      logic [7:0]  e8;
      string       nm;
      e32 = exp_q32.pop_front();
      e8  = exp_q8.pop_front();
      nm  = name_q.pop_front();
      compared++;
      if (seq_32 !== e32) begin
        mismatched++;
        $display("FAIL %s_w32: got %0d expected %0d at %0t", nm, seq_32, e32, $time);
      end
      compared++;
      if (seq_8 !== e8) begin
        mismatched++;
        $display("FAIL %s_w8: got %0d expected %0d at %0t", nm, seq_8, e8, $time);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] e32);
    exp_q32.push_back(e32);
    exp_q8.push_back(e32[7:0]);
    name_q.push_back(nm);
    -> sample_ev;
  endtask

  // Called just after reset is released between edges: samples T(0) then T(1..n-1)
  task automatic run_terms(input string nm, input int n);
    push_exp(nm, ref32[0]);
    for (int k = 1; k < n; k++) begin
      @(posedge clk);
      #1;
      push_exp(nm, ref32[k]);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    push_exp("reset_async", 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      push_exp("reset_hold", 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 50; i++) begin
      if (i < 20) ref32[i] = tbl[i];
      else        ref32[i] = ref32[i-2] + ref32[i-3];
    end

    // Repeated reset: identical sequence after each 3-cycle reset
    for (int pass = 0; pass < 3; pass++) begin
      apply_reset(3);
      run_terms("basic_seq", 50);
    end

    // Mid-sequence asynchronous reset pulse between edges
    apply_reset(3);
    run_terms("pre_mid", 20);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    push_exp("mid_async", 32'd0);
    @(posedge clk);
    #1;
    push_exp("mid_hold", 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    run_terms("post_mid", 50);

    // Held reset across many edges: state must not advance
    apply_reset(12);
    run_terms("after_held", 12);

    #20;
    compared++;
    if (exp_q32.size() != 0) begin
      mismatched++;
      $display("FAIL pending: got %0d unchecked entries expected 0", exp_q32.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
